multicycle_control: RTL and testbench

//  Multi-cycle MIPS control unit: a parametrised FSM that replaces the single-cycle opcode decoder.

---
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control.sv | 241 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control-unit <-> datapath/memory signal bundle
interface multicycle_control_if #(
  parameter int OPCODE_WIDTH = 6,
  parameter int ALU_OP_WIDTH = 3
);
  logic [OPCODE_WIDTH-1:0] opcode_i;
  logic                    zero_i;
  logic                    mem_ready_i;
  logic                    pc_write_o;
  logic                    ir_write_o;
  logic                    i_or_d_o;
  logic                    mem_read_o;
  logic                    mem_write_o;
  logic                    mem_to_reg_o;
  logic                    reg_dst_o;
  logic                    reg_write_o;
  logic                    alu_src_a_o;
  logic [1:0]              alu_src_b_o;
  logic [1:0]              pc_src_o;
  logic [ALU_OP_WIDTH-1:0] alu_op_o;
  logic                    illegal_op_o;
  logic                    mem_timeout_o;
  logic [2:0]              state_o;

  modport master (
    input  opcode_i, zero_i, mem_ready_i,
    output pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, mem_to_reg_o,
           reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, pc_src_o, alu_op_o,
           illegal_op_o, mem_timeout_o, state_o
  );

  modport slave (
    output opcode_i, zero_i, mem_ready_i,
    input  pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, mem_to_reg_o,
           reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, pc_src_o, alu_op_o,
           illegal_op_o, mem_timeout_o, state_o
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with memory handshake/timeout
// Optional jump support is compiled in with MC_CTRL_JUMP_EN.
module multicycle_control #(
  parameter int OPCODE_WIDTH = 6,
  parameter int ALU_OP_WIDTH = 3,
  parameter int MEM_TIMEOUT  = 0
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'h00);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'h08);
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = OPCODE_WIDTH'(6'h0d);
  localparam logic [OPCODE_WIDTH-1:0] OP_LUI   = OPCODE_WIDTH'(6'h0f);
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = OPCODE_WIDTH'(6'h0c);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'h23);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'h2b);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'h04);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = OPCODE_WIDTH'(6'h05);
`ifdef MC_CTRL_JUMP_EN
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'h02);
`endif

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = ALU_OP_WIDTH'(3'b000);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ORI  = ALU_OP_WIDTH'(3'b001);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LUI  = ALU_OP_WIDTH'(3'b010);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ANDI = ALU_OP_WIDTH'(3'b011);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LW   = ALU_OP_WIDTH'(3'b100);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SW   = ALU_OP_WIDTH'(3'b101);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = ALU_OP_WIDTH'(3'b110);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_R    = ALU_OP_WIDTH'(3'b111);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t                  state;
  state_t                  next_state;
  logic [OPCODE_WIDTH-1:0] opcode_r;
  logic [CNT_W-1:0]        wait_cnt;

  logic                    mem_phase;
  logic                    timeout_hit;
  logic                    dec_exec;
  logic                    dec_branch;
  logic                    dec_jump;
  logic                    is_rtype;
  logic                    is_lw;
  logic                    is_mem_op;
  logic [ALU_OP_WIDTH-1:0] exec_alu_op;

  logic                    pc_write;
  logic                    ir_write;
  logic                    i_or_d;
  logic                    mem_read;
  logic                    mem_write;
  logic                    mem_to_reg;
  logic                    reg_dst;
  logic                    reg_write;
  logic                    alu_src_a;
  logic [1:0]              alu_src_b;
  logic [1:0]              pc_src;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic                    illegal_op;
  logic                    mem_timeout;
  logic [2:0]              state_dbg;

  // Ready in the same cycle as the limit beats the timeout.
  always_comb begin
    mem_phase   = (state == S_FETCH) || (state == S_MEM);
    timeout_hit = 1'b0;
    if (MEM_TIMEOUT > 0) begin
      timeout_hit = mem_phase && !bus.mem_ready_i && (wait_cnt == CNT_W'(MEM_TIMEOUT));
    end
  end

  always_comb begin
    dec_exec   = 1'b0;
    dec_branch = 1'b0;
    dec_jump   = 1'b0;
    case (bus.opcode_i)
      OP_RTYPE, OP_ADDI, OP_ORI, OP_LUI, OP_ANDI, OP_LW, OP_SW: dec_exec = 1'b1;
      OP_BEQ, OP_BNE: dec_branch = 1'b1;
`ifdef MC_CTRL_JUMP_EN
      OP_J: dec_jump = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    is_rtype  = (opcode_r == OP_RTYPE);
    is_lw     = (opcode_r == OP_LW);
    is_mem_op = is_lw || (opcode_r == OP_SW);
    case (opcode_r)
      OP_ORI:  exec_alu_op = ALU_ORI;
      OP_LUI:  exec_alu_op = ALU_LUI;
      OP_ANDI: exec_alu_op = ALU_ANDI;
      OP_LW:   exec_alu_op = ALU_LW;
      OP_SW:   exec_alu_op = ALU_SW;
      default: exec_alu_op = ALU_ADD;
    endcase
  end

  // State register plus the per-instruction opcode latch and memory wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      opcode_r <= '0;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE && (dec_exec || dec_branch || dec_jump)) begin
        opcode_r <= bus.opcode_i;
      end
      if (state != next_state || timeout_hit) begin
        wait_cnt <= '0;
      end else if (mem_phase && !bus.mem_ready_i) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (bus.mem_ready_i) next_state = S_DECODE;
      end
      S_DECODE: begin
        if (dec_exec)        next_state = S_EXEC;
        else if (dec_branch) next_state = S_BRANCH;
        else if (dec_jump)   next_state = S_JUMP;
        else                 next_state = S_FETCH;
      end
      S_EXEC: begin
        next_state = is_mem_op ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (bus.mem_ready_i) next_state = is_lw ? S_WB : S_FETCH;
        else if (timeout_hit) next_state = S_FETCH;
      end
      S_WB, S_BRANCH, S_JUMP: next_state = S_FETCH;
      default: next_state = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_op      = ALU_ADD;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    state_dbg   = 3'd0;
    if (!reset) begin
      state_dbg   = state;
      mem_timeout = timeout_hit;
      case (state)
        S_FETCH: begin
          mem_read  = !timeout_hit;
          alu_src_b = 2'b01;
          if (bus.mem_ready_i) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = !(dec_exec || dec_branch || dec_jump);
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          if (is_rtype) begin
            alu_src_b = 2'b00;
            alu_op    = ALU_R;
          end else begin
            alu_src_b = 2'b10;
            alu_op    = exec_alu_op;
          end
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = is_lw && !timeout_hit;
          mem_write = !is_lw && !timeout_hit;
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = is_rtype;
          mem_to_reg = is_lw;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_src    = 2'b01;
          pc_write  = (opcode_r == OP_BEQ) ? bus.zero_i : !bus.zero_i;
        end
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write_o    = pc_write;
  assign bus.ir_write_o    = ir_write;
  assign bus.i_or_d_o      = i_or_d;
  assign bus.mem_read_o    = mem_read;
  assign bus.mem_write_o   = mem_write;
  assign bus.mem_to_reg_o  = mem_to_reg;
  assign bus.reg_dst_o     = reg_dst;
  assign bus.reg_write_o   = reg_write;
  assign bus.alu_src_a_o   = alu_src_a;
  assign bus.alu_src_b_o   = alu_src_b;
  assign bus.pc_src_o      = pc_src;
  assign bus.alu_op_o      = alu_op;
  assign bus.illegal_op_o  = illegal_op;
  assign bus.mem_timeout_o = mem_timeout;
  assign bus.state_o       = state_dbg;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed bench for multicycle_control (timeout 4 and wait-forever)
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       zero = 1'b0;
  logic       ready = 1'b1;
  int         checks = 0;
  int         failures = 0;
  logic       b_tmo_seen = 1'b0;

  always #5 clk = ~clk;

  multicycle_control_if #(.OPCODE_WIDTH(6), .ALU_OP_WIDTH(3)) bus_a ();
  multicycle_control_if #(.OPCODE_WIDTH(6), .ALU_OP_WIDTH(3)) bus_b ();

  assign bus_a.opcode_i    = opcode;
  assign bus_a.zero_i      = zero;
  assign bus_a.mem_ready_i = ready;
  assign bus_b.opcode_i    = opcode;
  assign bus_b.zero_i      = zero;
  assign bus_b.mem_ready_i = ready;

  multicycle_control #(.OPCODE_WIDTH(6), .ALU_OP_WIDTH(3), .MEM_TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  multicycle_control #(.OPCODE_WIDTH(6), .ALU_OP_WIDTH(3), .MEM_TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  logic [20:0] obs_a;
  logic [20:0] obs_b;
  assign obs_a = {bus_a.pc_write_o, bus_a.ir_write_o, bus_a.i_or_d_o, bus_a.mem_read_o,
                  bus_a.mem_write_o, bus_a.mem_to_reg_o, bus_a.reg_dst_o, bus_a.reg_write_o,
                  bus_a.alu_src_a_o, bus_a.alu_src_b_o, bus_a.pc_src_o, bus_a.alu_op_o,
                  bus_a.illegal_op_o, bus_a.mem_timeout_o, bus_a.state_o};
  assign obs_b = {bus_b.pc_write_o, bus_b.ir_write_o, bus_b.i_or_d_o, bus_b.mem_read_o,
                  bus_b.mem_write_o, bus_b.mem_to_reg_o, bus_b.reg_dst_o, bus_b.reg_write_o,
                  bus_b.alu_src_a_o, bus_b.alu_src_b_o, bus_b.pc_src_o, bus_b.alu_op_o,
                  bus_b.illegal_op_o, bus_b.mem_timeout_o, bus_b.state_o};

  always @(negedge clk) if (bus_b.mem_timeout_o) b_tmo_seen = 1'b1;

  // Field order: pcw irw iord mr mw m2r rd rw asa asb pcs aop ill tmo st
  function automatic logic [20:0] v(input logic pcw, irw, iord, mr, mw, m2r, rd, rw, asa,
                                    input logic [1:0] asb, pcs, input logic [2:0] aop,
                                    input logic ill, tmo, input logic [2:0] st);
    return {pcw, irw, iord, mr, mw, m2r, rd, rw, asa, asb, pcs, aop, ill, tmo, st};
  endfunction

  task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic [5:0] op, input logic z,
                      input string tag, input logic [20:0] exp);
    @(posedge clk);
    #1;
    ready  = rdy;
    opcode = op;
    zero   = z;
    #1;
    chk(tag, obs_a, exp);
  endtask

  logic [20:0] f_go, f_wait, f_tmo, dec, dec_ill;
  logic [5:0]  imm_ops [4];
  logic [2:0]  imm_aop [4];

  initial begin
    f_go    = v(1,1,0,1,0,0,0,0,0,2'b01,2'b00,3'b000,0,0,3'd0);
    f_wait  = v(0,0,0,1,0,0,0,0,0,2'b01,2'b00,3'b000,0,0,3'd0);
    f_tmo   = v(0,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b000,0,1,3'd0);
    dec     = v(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,0,0,3'd1);
    dec_ill = v(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,1,0,3'd1);
    imm_ops = '{6'h08, 6'h0d, 6'h0f, 6'h0c};
    imm_aop = '{3'b000, 3'b001, 3'b010, 3'b011};

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      chk("reset_a", obs_a, 21'd0);
      chk("reset_b", obs_b, 21'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("fetch_after_reset", obs_a, f_go);

    step(1, 6'h00, 0, "add_decode", dec);
    step(1, 6'h00, 0, "add_exec",   v(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111,0,0,3'd2));
    step(1, 6'h00, 0, "add_wb",     v(0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0,0,3'd4));

    step(1, 6'h23, 0, "lw_fetch",   f_go);
    step(1, 6'h23, 0, "lw_decode",  dec);
    step(1, 6'h23, 0, "lw_exec",    v(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b100,0,0,3'd2));
    step(0, 6'h23, 0, "lw_mem_w1",  v(0,0,1,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,0,3'd3));
    step(0, 6'h23, 0, "lw_mem_w2",  v(0,0,1,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,0,3'd3));
    step(1, 6'h23, 0, "lw_mem_rdy", v(0,0,1,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,0,3'd3));
    step(1, 6'h23, 0, "lw_wb",      v(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,0,3'd4));

    step(1, 6'h2b, 0, "sw_fetch",   f_go);
    step(1, 6'h2b, 0, "sw_decode",  dec);
    step(1, 6'h2b, 0, "sw_exec",    v(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b101,0,0,3'd2));
    step(1, 6'h2b, 0, "sw_mem",     v(0,0,1,0,1,0,0,0,0,2'b00,2'b00,3'b000,0,0,3'd3));

    for (int k = 0; k < 4; k++) begin
      step(1, imm_ops[k], 0, "imm_fetch",  f_go);
      step(1, imm_ops[k], 0, "imm_decode", dec);
      step(1, imm_ops[k], 0, "imm_exec",   v(0,0,0,0,0,0,0,0,1,2'b10,2'b00,imm_aop[k],0,0,3'd2));
      step(1, imm_ops[k], 0, "imm_wb",     v(0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0,0,3'd4));
    end

    step(1, 6'h04, 1, "beq_fetch",   f_go);
    step(1, 6'h04, 1, "beq_decode",  dec);
    step(1, 6'h04, 1, "beq_z1",      v(1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,0,3'd5));
    step(1, 6'h05, 1, "bne_fetch",   f_go);
    step(1, 6'h05, 1, "bne_decode",  dec);
    step(1, 6'h05, 1, "bne_z1",      v(0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,0,3'd5));
    step(1, 6'h05, 0, "bne_fetch2",  f_go);
    step(1, 6'h05, 0, "bne_decode2", dec);
    step(1, 6'h05, 0, "bne_z0",      v(1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,0,3'd5));
    step(1, 6'h04, 0, "beq_fetch2",  f_go);
    step(1, 6'h04, 0, "beq_decode2", dec);
    step(1, 6'h04, 0, "beq_z0",      v(0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0,0,3'd5));

    step(1, 6'h3f, 0, "ill_fetch",   f_go);
    step(1, 6'h3f, 0, "ill_decode",  dec_ill);
    step(0, 6'h3f, 0, "ill_refetch", f_wait);

    step(1, 6'h02, 0, "j_fetch",     f_go);
`ifdef MC_CTRL_JUMP_EN
    step(1, 6'h02, 0, "j_decode",    dec);
    step(1, 6'h02, 0, "j_jump",      v(1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0,0,3'd6));
`else
    step(1, 6'h02, 0, "j_illegal",   dec_ill);
`endif

    for (int i = 0; i < 4; i++) step(0, 6'h00, 0, "tmo_wait", f_wait);
    step(0, 6'h00, 0, "tmo_pulse",        f_tmo);
    step(0, 6'h00, 0, "tmo_refetch_wait", f_wait);
    step(1, 6'h2b, 0, "tmo_refetch_go",   f_go);

    step(1, 6'h2b, 0, "sw2_decode", dec);
    step(1, 6'h2b, 0, "sw2_exec",   v(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b101,0,0,3'd2));
    for (int i = 0; i < 4; i++)
      step(0, 6'h2b, 0, "sw2_mem_wait", v(0,0,1,0,1,0,0,0,0,2'b00,2'b00,3'b000,0,0,3'd3));
    step(0, 6'h2b, 0, "sw2_mem_tmo",  v(0,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,1,3'd3));
    step(0, 6'h2b, 0, "sw2_refetch",  f_wait);

    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
    end
    chk("b_still_mem", obs_b, v(0,0,1,0,1,0,0,0,0,2'b00,2'b00,3'b000,0,0,3'd3));
    chk("b_no_timeout", {20'd0, b_tmo_seen}, 21'd0);

    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("reset2_a", obs_a, 21'd0);
    chk("reset2_b", obs_b, 21'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ready = 1'b1;
    opcode = 6'h00;
    #1;
    chk("fetch_after_reset2_b", obs_b, f_go);
    chk("fetch_after_reset2_a", obs_a, f_go);
    step(1, 6'h00, 0, "mid_decode", dec);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_reset_exec", obs_a, 21'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_reset_fetch", obs_a, f_go);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
